// File: rtl/dmem_lsu_master.sv
// Load/store initiator for the RAM data port: one outstanding request, aligned word
// accesses with byte-lane steering, load extension and misalign/range error reporting.
module dmem_lsu_master #(
   parameter int unsigned WIDTH     = 64,
   parameter logic [63:0] ADDR_BASE = 64'h8000_0000,
   parameter logic [63:0] RAM_BYTES = 64'h0800_0000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_wen,
   input  logic [1:0]       req_size,
   input  logic             req_signed,
   input  logic [WIDTH-1:0] req_addr,
   input  logic [WIDTH-1:0] req_wdata,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic [WIDTH-1:0] resp_rdata,
   output logic             resp_err,
   output logic             dmem_en,
   output logic [WIDTH-1:0] dmem_addr,
   input  logic [WIDTH-1:0] dmem_rdata,
   output logic [WIDTH-1:0] dmem_wdata,
   output logic [WIDTH-1:0] dmem_wmask,
   output logic             dmem_wen
);

   localparam int unsigned LANES = WIDTH / 8;
   localparam logic [64:0] LIMIT = {1'b0, ADDR_BASE} + {1'b0, RAM_BYTES};

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t           state;
   logic             wen_q;
   logic [1:0]       size_q;
   logic             signed_q;
   logic [2:0]       off_q;

   logic [3:0]       bytes_c;
   logic [7:0]       lane_c;
   logic [7:0]       bmask_c;
   logic [64:0]      end_c;
   logic             misalign_c;
   logic             oor_c;
   logic [WIDTH-1:0] wdata_c;
   logic [WIDTH-1:0] wmask_c;
   logic [WIDTH-1:0] raw_c;
   logic [WIDTH-1:0] load_c;

   // Request decode: error detection and store lane steering from the live request.
   always_comb begin
      bytes_c = 4'(1) << req_size;
      lane_c  = 8'h00;
      misalign_c = 1'b0;
      case (req_size)
         2'd0: begin lane_c = 8'h01; misalign_c = 1'b0; end
         2'd1: begin lane_c = 8'h03; misalign_c = req_addr[0]; end
         2'd2: begin lane_c = 8'h0F; misalign_c = |req_addr[1:0]; end
         default: begin lane_c = 8'hFF; misalign_c = |req_addr[2:0]; end
      endcase
      bmask_c = lane_c << req_addr[2:0];
      end_c   = {1'b0, req_addr} + 65'(bytes_c);
      oor_c   = (req_addr < ADDR_BASE) || (end_c > LIMIT);
      wdata_c = req_wdata << {req_addr[2:0], 3'b000};
      wmask_c = '0;
      for (int i = 0; i < LANES; i++) begin
         wmask_c[8*i +: 8] = {8{bmask_c[i]}};
      end
   end

   // Load return path: shift the addressed lane down, then truncate and extend.
   always_comb begin
      raw_c  = dmem_rdata >> {off_q, 3'b000};
      load_c = '0;
      case (size_q)
         2'd0: load_c = signed_q ? {{56{raw_c[7]}},  raw_c[7:0]}  : {56'd0, raw_c[7:0]};
         2'd1: load_c = signed_q ? {{48{raw_c[15]}}, raw_c[15:0]} : {48'd0, raw_c[15:0]};
         2'd2: load_c = signed_q ? {{32{raw_c[31]}}, raw_c[31:0]} : {32'd0, raw_c[31:0]};
         default: load_c = raw_c;
      endcase
   end

   // Async reset clears dmem_* at once, so a reset mid-ACCESS cannot write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         wen_q      <= 1'b0;
         size_q     <= 2'd0;
         signed_q   <= 1'b0;
         off_q      <= 3'd0;
         req_ready  <= 1'b1;
         resp_valid <= 1'b0;
         resp_rdata <= '0;
         resp_err   <= 1'b0;
         dmem_en    <= 1'b0;
         dmem_wen   <= 1'b0;
         dmem_addr  <= '0;
         dmem_wdata <= '0;
         dmem_wmask <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  wen_q     <= req_wen;
                  size_q    <= req_size;
                  signed_q  <= req_signed;
                  off_q     <= req_addr[2:0];
                  req_ready <= 1'b0;
                  if (misalign_c || oor_c) begin
                     state      <= RESP;
                     resp_valid <= 1'b1;
                     resp_err   <= 1'b1;
                     resp_rdata <= '0;
                  end else begin
                     state      <= ACCESS;
                     dmem_en    <= 1'b1;
                     dmem_wen   <= req_wen;
                     dmem_addr  <= {req_addr[WIDTH-1:3], 3'b000};
                     dmem_wdata <= req_wen ? wdata_c : '0;
                     dmem_wmask <= req_wen ? wmask_c : '0;
                  end
               end
            end
            ACCESS: begin
               state      <= RESP;
               dmem_en    <= 1'b0;
               dmem_wen   <= 1'b0;
               dmem_addr  <= '0;
               dmem_wdata <= '0;
               dmem_wmask <= '0;
               resp_valid <= 1'b1;
               resp_err   <= 1'b0;
               resp_rdata <= wen_q ? '0 : load_c;
            end
            RESP: begin
               if (resp_ready) begin
                  state      <= IDLE;
                  resp_valid <= 1'b0;
                  resp_rdata <= '0;
                  resp_err   <= 1'b0;
                  req_ready  <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
